reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 114 +++++++++++
 tb/tb_reaction_timer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random wait, stimulus LED, then it counts ms until the player responds.
// All outputs are registered; a result is held until the next start.
module reaction_timer #(
    parameter int STEP_MS = 500,
    parameter int MAX_MS  = 9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_ms,
    input  logic        start,
    input  logic        react,
    input  logic [3:0]  randNum,
    output logic        stop,
    output logic        go,
    output logic        early,
    output logic        timeout,
    output logic [13:0] react_ms,
    output logic        busy
);

    // state | meaning
    // IDLE  | between rounds, random generator free-running
    // WAIT  | random delay counting down, LED off
    // GO    | LED lit, counting reaction ms
    // DONE  | valid reaction (or timeout) result held
    // FAULT | false start result held
    typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FAULT} state_t;

    localparam logic [13:0] MAX_CNT = 14'(MAX_MS);

    state_t      state;
    logic [12:0] delay_cnt;
    logic [13:0] react_cnt;
    logic [3:0]  n_clamp;
    logic [12:0] delay_load;

    assign n_clamp    = (randNum > 4'd9) ? 4'd9 : randNum;
    assign delay_load = 13'((32'(n_clamp) + 32'd1) * 32'(STEP_MS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            delay_cnt <= '0;
            react_cnt <= '0;
            react_ms  <= '0;
            go        <= 1'b0;
            early     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            stop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        delay_cnt <= delay_load;
                        state     <= WAIT;
                        busy      <= 1'b1;
                        stop      <= 1'b1;
                    end
                end
                WAIT: begin
                    // a response before the LED is a false start, even on the final tick
                    if (react) begin
                        state    <= FAULT;
                        early    <= 1'b1;
                        react_ms <= '0;
                        busy     <= 1'b0;
                    end else if (tick_ms) begin
                        delay_cnt <= delay_cnt - 13'd1;
                        if (delay_cnt == 13'd1) begin
                            state     <= GO;
                            react_cnt <= '0;
                            go        <= 1'b1;
                        end
                    end
                end
                GO: begin
                    if (react) begin
                        state    <= DONE;
                        react_ms <= react_cnt;
                        go       <= 1'b0;
                        busy     <= 1'b0;
                    end else if (tick_ms) begin
                        if (react_cnt == MAX_CNT) begin
                            state    <= DONE;
                            timeout  <= 1'b1;
                            react_ms <= MAX_CNT;
                            go       <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            react_cnt <= react_cnt + 14'd1;
                        end
                    end
                end
                DONE, FAULT: begin
                    if (start) begin
                        state    <= IDLE;
                        early    <= 1'b0;
                        timeout  <= 1'b0;
                        react_ms <= '0;
                        stop     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    go    <= 1'b0;
                    busy  <= 1'b0;
                    stop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: normal round, false start, timeout, collisions, mid-round reset.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_reaction_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_ms = 1'b0;
    logic        start = 1'b0;
    logic        react = 1'b0;
    logic [3:0]  randNum = 4'd0;
    logic        stop, go, early, timeout, busy;
    logic [13:0] react_ms;

    int passed = 0;
    int total  = 0;

    reaction_timer dut (
        .clk(clk), .reset(reset), .tick_ms(tick_ms), .start(start), .react(react),
        .randNum(randNum), .stop(stop), .go(go), .early(early), .timeout(timeout),
        .react_ms(react_ms), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1; cyc();
            tick_ms = 1'b0; cyc();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_react();
        react = 1'b1; cyc(); react = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cyc(); cyc();
        total++; if ({stop, go, early, timeout, busy} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {stop, go, early, timeout, busy}); else passed++;
        total++; if (react_ms !== 14'd0) $display("FAIL reset_react_ms got %0d want 0", react_ms); else passed++;
        reset = 1'b0; cyc();
    endtask

    task automatic test_normal();
        randNum = 4'd3;
        pulse_start();
        total++; if ({busy, stop, go} !== 3'b110) $display("FAIL normal_wait_entry got %b want 110", {busy, stop, go}); else passed++;
        ticks(1999);
        total++; if (go !== 1'b0) $display("FAIL normal_go_1999 got %b want 0", go); else passed++;
        ticks(1);
        total++; if (go !== 1'b1) $display("FAIL normal_go_2000 got %b want 1", go); else passed++;
        ticks(250);
        pulse_react();
        total++; if (react_ms !== 14'd250) $display("FAIL normal_react_ms got %0d want 250", react_ms); else passed++;
        total++; if ({go, busy, timeout, early, stop} !== 5'b00001) $display("FAIL normal_done_flags got %b want 00001", {go, busy, timeout, early, stop}); else passed++;
        ticks(5); pulse_react();
        total++; if (react_ms !== 14'd250) $display("FAIL normal_hold got %0d want 250", react_ms); else passed++;
        pulse_start();
        total++; if ({react_ms, stop, busy} !== 16'd0) $display("FAIL normal_back_idle got %0d/%b/%b want 0/0/0", react_ms, stop, busy); else passed++;
        cyc(); cyc();
        total++; if (busy !== 1'b0) $display("FAIL normal_no_autostart got %b want 0", busy); else passed++;
    endtask

    task automatic test_early();
        randNum = 4'd0;
        pulse_start();
        ticks(300);
        pulse_react();
        total++; if ({early, go, busy, stop} !== 4'b1001) $display("FAIL early_flags got %b want 1001", {early, go, busy, stop}); else passed++;
        total++; if (react_ms !== 14'd0) $display("FAIL early_react_ms got %0d want 0", react_ms); else passed++;
        ticks(600);
        total++; if ({early, go} !== 2'b10) $display("FAIL early_hold got %b want 10", {early, go}); else passed++;
        pulse_start();
        total++; if ({early, stop, busy} !== 3'b000) $display("FAIL early_clear got %b want 000", {early, stop, busy}); else passed++;
        pulse_react();
        total++; if ({early, busy} !== 2'b00) $display("FAIL idle_react_ignored got %b want 00", {early, busy}); else passed++;
        start = 1'b1; react = 1'b1; cyc(); start = 1'b0; react = 1'b0;
        total++; if ({busy, early, stop} !== 3'b101) $display("FAIL start_react_same got %b want 101", {busy, early, stop}); else passed++;
        pulse_react();
        pulse_start();
    endtask

    task automatic test_timeout();
        randNum = 4'd12;
        pulse_start();
        ticks(4999);
        total++; if (go !== 1'b0) $display("FAIL clamp_go_4999 got %b want 0", go); else passed++;
        ticks(1);
        total++; if (go !== 1'b1) $display("FAIL clamp_go_5000 got %b want 1", go); else passed++;
        ticks(9999);
        total++; if ({go, timeout} !== 2'b10) $display("FAIL timeout_9999 got %b want 10", {go, timeout}); else passed++;
        ticks(1);
        total++; if ({go, timeout, busy} !== 3'b010) $display("FAIL timeout_flags got %b want 010", {go, timeout, busy}); else passed++;
        total++; if (react_ms !== 14'd9999) $display("FAIL timeout_react_ms got %0d want 9999", react_ms); else passed++;
        pulse_start();
        total++; if ({timeout, react_ms} !== 15'd0) $display("FAIL timeout_clear got %b/%0d want 0/0", timeout, react_ms); else passed++;
    endtask

    task automatic test_collisions();
        randNum = 4'd0;
        pulse_start();
        ticks(499);
        tick_ms = 1'b1; react = 1'b1; cyc(); tick_ms = 1'b0; react = 1'b0;
        total++; if ({early, go} !== 2'b10) $display("FAIL coll_wait got %b want 10", {early, go}); else passed++;
        cyc(); pulse_start();
        pulse_start();
        ticks(500);
        ticks(40);
        tick_ms = 1'b1; react = 1'b1; cyc(); tick_ms = 1'b0; react = 1'b0;
        total++; if (react_ms !== 14'd40) $display("FAIL coll_go got %0d want 40", react_ms); else passed++;
        pulse_start();
        pulse_start();
        ticks(500);
        ticks(10);
        pulse_start();
        total++; if ({go, busy} !== 2'b11) $display("FAIL go_start_ignored got %b want 11", {go, busy}); else passed++;
        ticks(5);
        pulse_react();
        total++; if (react_ms !== 14'd15) $display("FAIL go_start_count got %0d want 15", react_ms); else passed++;
        pulse_start();
    endtask

    task automatic test_reset_go();
        randNum = 4'd1;
        pulse_start();
        ticks(1000);
        ticks(100);
        pulse_start();
        ticks(23);
        total++; if ({go, busy} !== 2'b11) $display("FAIL rgo_before got %b want 11", {go, busy}); else passed++;
        #2 reset = 1'b1; #1;
        total++; if ({stop, go, early, timeout, busy} !== 5'b0 || react_ms !== 14'd0) $display("FAIL rgo_async got %b/%0d want 00000/0", {stop, go, early, timeout, busy}, react_ms); else passed++;
        cyc(); reset = 1'b0; cyc();
        pulse_react();
        total++; if ({busy, early, react_ms} !== 16'd0) $display("FAIL rgo_idle got %b/%b/%0d want 0/0/0", busy, early, react_ms); else passed++;
        randNum = 4'd0;
        pulse_start();
        ticks(500);
        ticks(7);
        pulse_react();
        total++; if (react_ms !== 14'd7) $display("FAIL rgo_resume got %0d want 7", react_ms); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_early();
        test_timeout();
        test_collisions();
        test_reset_go();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
